// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: byte-serial command sequencer driving an ALU and returning result + flags
//   i_clk, i_rst_n           clock (rising edge), asynchronous active-low reset
//   i_rx_data, i_rx_valid    received byte and its one-cycle valid pulse (A, B, opcode)
//   o_dato_a, o_dato_b, o_op registered operands and opcode presented to the ALU
//   i_alu_res, i_alu_carry   combinational ALU result and carry/borrow
//   o_tx_data, o_tx_start    byte to send and one-cycle start pulse (result, then flags)
//   i_tx_done                one-cycle pulse when the transmitter finishes a byte
//   o_busy                   high whenever a command is in progress
module alu_cmd_ctrl #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_DATA-1:0] o_dato_a,
    output logic [NB_DATA-1:0] o_dato_b,
    output logic [NB_OP-1:0]   o_op,
    input  logic [NB_DATA-1:0] i_alu_res,
    input  logic               i_alu_carry,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy
);
    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'('h20);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'('h22);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'('h24);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'('h25);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'('h26);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'('h03);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'('h02);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'('h27);

    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG
    } state_t;

    state_t             r_state, w_next;
    logic [NB_DATA-1:0] r_dato_a, r_dato_b, r_tx_data, r_flags;
    logic [NB_OP-1:0]   r_op;
    logic               r_invalid, r_tx_start, r_busy;
    logic [NB_OP-1:0]   w_rx_op;
    logic               w_op_valid, w_carry, w_zero;
    logic [NB_DATA-1:0] w_res, w_flags;

    assign w_rx_op    = i_rx_data[NB_OP-1:0];
    // Opcode byte must have its spare high bits clear and name a supported operation.
    assign w_op_valid = (i_rx_data[NB_DATA-1:NB_OP] == '0) &&
                        (w_rx_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR});
    // Invalid commands report a zero result with no carry, so the zero flag comes out set.
    assign w_res      = r_invalid ? '0 : i_alu_res;
    assign w_carry    = !r_invalid && i_alu_carry;
    assign w_zero     = (w_res == '0);
    assign w_flags    = {r_invalid, {(NB_DATA-3){1'b0}}, w_zero, w_carry};

    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_A:   w_next = i_rx_valid ? WAIT_B : WAIT_A;
            WAIT_B:   w_next = i_rx_valid ? WAIT_OP : WAIT_B;
            WAIT_OP:  w_next = i_rx_valid ? EXEC : WAIT_OP;
            EXEC:     w_next = SEND_RES;
            SEND_RES: w_next = WAIT_RES;
            WAIT_RES: w_next = i_tx_done ? SEND_FLG : WAIT_RES;
            SEND_FLG: w_next = WAIT_FLG;
            WAIT_FLG: w_next = i_tx_done ? WAIT_A : WAIT_FLG;
            default:  w_next = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= WAIT_A;
            r_dato_a   <= '0;
            r_dato_b   <= '0;
            r_op       <= '0;
            r_invalid  <= 1'b0;
            r_flags    <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next;
            // Start pulse and busy are computed from the next state so they stay true flops.
            r_tx_start <= (w_next == SEND_RES) || (w_next == SEND_FLG);
            r_busy     <= (w_next != WAIT_A);
            if (r_state == WAIT_A && i_rx_valid)
                r_dato_a <= i_rx_data;
            if (r_state == WAIT_B && i_rx_valid)
                r_dato_b <= i_rx_data;
            if (r_state == WAIT_OP && i_rx_valid) begin
                r_op      <= w_rx_op;
                r_invalid <= !w_op_valid;
            end
            // The result byte goes straight into the transmit register; flags wait their turn.
            if (r_state == EXEC) begin
                r_tx_data <= w_res;
                r_flags   <= w_flags;
            end
            if (r_state == WAIT_RES && i_tx_done)
                r_tx_data <= r_flags;
        end
    end

    assign o_dato_a   = r_dato_a;
    assign o_dato_b   = r_dato_b;
    assign o_op       = r_op;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = r_busy;
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: directed and randomized command sequences against a reference model
module tb_alu_cmd_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0, tx_done = 1'b0;
    logic [7:0] dato_a, dato_b, alu_res, tx_data;
    logic [5:0] op;
    logic       alu_carry, tx_start, busy;
    int         n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_cmd_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_dato_a(dato_a), .o_dato_b(dato_b), .o_op(op),
        .i_alu_res(alu_res), .i_alu_carry(alu_carry),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done), .o_busy(busy)
    );

    // Stand-in ALU; unknown opcodes produce nonzero garbage that the controller must suppress.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] o);
        case (o)
            6'h20:   return {1'b0, a} + {1'b0, b};
            6'h22:   return {a < b, 8'(a - b)};
            6'h24:   return {1'b0, a & b};
            6'h25:   return {1'b0, a | b};
            6'h26:   return {1'b0, a ^ b};
            6'h03:   return {1'b0, 8'($signed(a) >>> b)};
            6'h02:   return {1'b0, a >> b};
            6'h27:   return {1'b0, ~(a | b)};
            default: return 9'h1AB;
        endcase
    endfunction

    assign {alu_carry, alu_res} = alu_fn(dato_a, dato_b, op);

    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         output logic [7:0] er, output logic [7:0] ef);
        logic [8:0] r;
        if (!(opb inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27})) begin
            er = 8'h00;
            ef = 8'h82;
        end else begin
            r  = alu_fn(a, b, opb[5:0]);
            er = r[7:0];
            ef = {6'b0, r[7:0] == 8'h00, r[8]};
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // mode 0: normal, 1: coincident done + stray byte in WAIT_RES, 2: reset during WAIT_FLG
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input logic [7:0] er, input logic [7:0] ef, input int mode);
        send(a);
        chk("busy_after_a", busy, 1);
        send(b);
        chk("dato_a", dato_a, a);
        send(opb);
        chk("dato_b", dato_b, b);
        chk("op", op, opb[5:0]);
        chk("exec_no_start", tx_start, 0);
        @(negedge clk);
        chk("res_start", tx_start, 1);
        chk("res_data", tx_data, er);
        if (mode == 1) begin
            pulse_done();
            chk("res_start_one_cycle", tx_start, 0);
            send(8'hAA);
            repeat (2) @(negedge clk);
            chk("res_held", tx_data, er);
            chk("no_early_flags", tx_start, 0);
            chk("stray_byte_dropped", dato_a, a);
        end else begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        pulse_done();
        chk("flg_start", tx_start, 1);
        chk("flg_data", tx_data, ef);
        @(negedge clk);
        if (mode == 2) begin
            rst_n = 1'b0;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_tx_start", tx_start, 0);
            chk("rst_tx_data", tx_data, 0);
            chk("rst_ops", {dato_a, dato_b, 2'b00, op}, 0);
            #3 rst_n = 1'b1;
            @(negedge clk);
            chk("rst_idle", busy, 0);
        end else begin
            chk("flg_hold", tx_data, ef);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse_done();
            chk("idle_busy", busy, 0);
            chk("idle_start", tx_start, 0);
        end
    endtask

    initial begin
        logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
        logic [7:0] a, b, opb, er, ef;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_outputs", {dato_a, dato_b, tx_data, 2'b00, op, 7'b0, tx_start}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(8'hF0, 8'h20, 8'h20, 8'h10, 8'h01, 0);
        run_cmd(8'h05, 8'h05, 8'h22, 8'h00, 8'h02, 0);
        run_cmd(8'h03, 8'h05, 8'h22, 8'hFE, 8'h01, 0);
        run_cmd(8'h80, 8'h02, 8'h03, 8'hE0, 8'h00, 0);
        run_cmd(8'h80, 8'h02, 8'h02, 8'h20, 8'h00, 0);
        run_cmd(8'h12, 8'h34, 8'h3F, 8'h00, 8'h82, 0);
        run_cmd(8'h12, 8'h34, 8'h60, 8'h00, 8'h82, 0);
        run_cmd(8'h12, 8'h34, 8'h24, 8'h10, 8'h00, 1);
        run_cmd(8'h12, 8'h34, 8'h26, 8'h26, 8'h00, 2);
        run_cmd(8'h0F, 8'hF0, 8'h25, 8'hFF, 8'h00, 0);
        for (int i = 0; i < 24; i++) begin
            a   = 8'($urandom);
            b   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            opb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 7)];
            model(a, b, opb, er, ef);
            run_cmd(a, b, opb, er, ef, (i % 6 == 5) ? 1 : 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command sequencer that sits on the operand side of the ALU. It collects three serial bytes (A, B, opcode) from a byte receiver, drives the registered operands and opcode into the combinational ALU, and captures the result and carry. It then returns two bytes (result, flags) through a byte transmitter handshake. It is the controlling end of the ALU's operand/result interface in the UART-attached top level.

Parameters:
NB_DATA, 8, width of operands, result and serial bytes
NB_OP, 6, opcode width driven to the ALU (NB_DATA-2)

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_rx_data  input  NB_DATA  received byte, valid when i_rx_valid=1
i_rx_valid  input  1  one-cycle pulse per received byte
o_dato_a  output  NB_DATA  registered operand A to ALU
o_dato_b  output  NB_DATA  registered operand B to ALU
o_op  output  NB_OP  registered opcode to ALU
i_alu_res  input  NB_DATA  ALU result (combinational from o_dato_a/b/o_op)
i_alu_carry  input  1  ALU carry/borrow
o_tx_data  output  NB_DATA  byte to transmit; stable from o_tx_start until i_tx_done
o_tx_start  output  1  one-cycle pulse requesting transmission of o_tx_data
i_tx_done  input  1  one-cycle pulse when transmitter finishes a byte
o_busy  output  1  high in any state other than WAIT_A

Behaviour:
- Reset (async, i_rst_n=0): state=WAIT_A; o_dato_a, o_dato_b, o_op, o_tx_data, internal result/flags = 0; o_tx_start=0; o_busy=0. Reset mid-operation aborts immediately, with no partial transmission resumed.
- FSM states: WAIT_A -> WAIT_B -> WAIT_OP -> EXEC -> SEND_RES -> WAIT_RES -> SEND_FLG -> WAIT_FLG -> WAIT_A.
- WAIT_A/WAIT_B: on i_rx_valid, load o_dato_a/o_dato_b on that edge and advance.
- WAIT_OP: on i_rx_valid, load o_op=i_rx_data[NB_OP-1:0]; set internal invalid flag if i_rx_data[NB_DATA-1:NB_OP]!=0 or the low bits are not one of 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x03 SRA, 0x02 SRL, 0x27 NOR. Advance to EXEC.
- EXEC (exactly 1 cycle): operands are stable, so latch res=i_alu_res and flags={invalid,5'b0,zero,carry}, where zero=(i_alu_res==0) and carry=i_alu_carry. Invalid ops latch res=0x00 and carry=0, forcing zero=1.
- SEND_RES: o_tx_data=res; o_tx_start=1 for this single cycle; go to WAIT_RES.
- WAIT_RES: hold o_tx_data; on i_tx_done go to SEND_FLG. i_tx_done is only sampled in WAIT_* states, so a done pulse coincident with o_tx_start is ignored.
- SEND_FLG/WAIT_FLG: same as the result phase, with o_tx_data=flags.
- Latency: opcode byte valid at edge N -> EXEC during cycle N+1 -> o_tx_start high at cycle N+2 with result. i_tx_done at edge M -> flags o_tx_start at M+1. Final i_tx_done at edge K -> WAIT_A and o_busy=0 at K+1.
- i_rx_valid in any state from EXEC through WAIT_FLG: byte dropped with no state change.
- o_dato_a/o_dato_b/o_op hold their last values until overwritten by the next command. Partially received commands persist indefinitely, with no timeout.
- Back-to-back commands: an A byte arriving in the cycle after returning to WAIT_A is accepted.
- All outputs are registered; no combinational path from i_rx_* to o_tx_*.

Test Plan:
- Reset, then bytes 0xF0, 0x20, 0x20 (ADD) -> tx 0x10, then flags 0x01; o_busy low one cycle after second i_tx_done.
- Bytes 0x05, 0x05, 0x22 (SUB) -> tx 0x00, flags 0x02; bytes 0x03, 0x05, 0x22 -> tx 0xFE, flags 0x01 (borrow).
- Bytes 0x80, 0x02, 0x03 (SRA) -> tx 0xE0, flags 0x00; with opcode 0x02 (SRL) -> tx 0x20, flags 0x00.
- Invalid opcode bytes 0x3F and 0x60 (after A=0x12, B=0x34) -> tx 0x00, flags 0x82 each; FSM returns to WAIT_A.
- Inject i_rx_valid 0xAA during WAIT_RES, and i_tx_done coincident with o_tx_start -> byte ignored, done ignored; FSM waits for the next i_tx_done and the result is unchanged.
- Assert i_rst_n=0 during WAIT_FLG -> all outputs 0 asynchronously; after release, a fresh command 0x0F, 0xF0, 0x25 (OR) -> tx 0xFF, flags 0x00.
